// File: rtl/gbe_snap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gbe_snap_pkg
// Brief    : Shared types and bit-index constants for the 10GbE TX snapshot
//            capture controller.
// Revision : 1.0 - initial release
// ============================================================================
package gbe_snap_pkg;

    // Capture controller states; DELAY is only reachable when the trigger
    // delay feature (SNAP_TRIG_DELAY_EN) is compiled in.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } snap_state_t;

    // Control word bit positions
    localparam int CTRL_ARM      = 0;
    localparam int CTRL_TRIG_SRC = 1;
    localparam int CTRL_WE_SRC   = 2;
    localparam int CTRL_DLY_LSB  = 16;

    // Status word bit positions
    localparam int STAT_DONE = 31;
    localparam int STAT_BUSY = 30;

    // Busy covers every state between arming and completion
    function automatic logic snap_is_busy(input snap_state_t s);
        return (s == ST_ARMED) || (s == ST_DELAY) || (s == ST_CAPTURE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/snap_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : snap_edge_detect
// Brief    : Registered rising-edge detector for the software arm bit.
//            rise is high for the single cycle where level is 1 and the
//            previous-cycle copy is 0.
// Revision : 1.0 - initial release
// ============================================================================
module snap_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic r_level_q;

    // Previous-cycle copy of the level; cleared by reset so a level already
    // high when reset releases is seen as a fresh edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= level;
        end
    end

    assign rise = level & ~r_level_q;

endmodule
`default_nettype wire

// File: rtl/gbe_tx_snapshot_capture.sv
`default_nettype none
// ============================================================================
// Module   : gbe_tx_snapshot_capture
// Brief    : 10GbE TX snapshot capture controller. Arms on a rising edge of
//            the control-word arm bit, waits for a qualified trigger, then
//            writes 2^ADDR_W samples into the snapshot BRAM and reports
//            done/busy/count in a registered status word.
//            Optional feature macro: SNAP_TRIG_DELAY_EN (trigger delay in
//            qualified samples taken from ctrl_word[31:16]).
// Revision : 1.0 - initial release
// ============================================================================
module gbe_tx_snapshot_capture
    import gbe_snap_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int DLY_W  = 16
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       ctrl_word,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              din_trig,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_data,
    output logic [31:0]       status_word,
    output logic              done
);

    localparam logic [ADDR_W:0] C_CNT_ONE = (ADDR_W+1)'(1);

    snap_state_t       r_state;
    logic [ADDR_W:0]   r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_done;
    logic [31:0]       r_status;
    logic [31:0]       w_status;
    logic              w_arm_edge;
    logic              w_vld;
    logic              w_trg;
    logic              w_last;

`ifdef SNAP_TRIG_DELAY_EN
    logic [DLY_W-1:0]  r_dly;
    logic [DLY_W-1:0]  w_dly_load;
    logic              w_unused_ctrl;

    assign w_dly_load    = ctrl_word[CTRL_DLY_LSB +: DLY_W];
    assign w_unused_ctrl = ^ctrl_word[15:3];
`else
    logic              w_unused_ctrl;

    // Delay field has no meaning without the delay feature
    assign w_unused_ctrl = ^{ctrl_word[31:16], ctrl_word[15:3]};
`endif

    snap_edge_detect u_arm_edge (
        .clk   (user_clk),
        .rst_n (user_rst_n),
        .level (ctrl_word[CTRL_ARM]),
        .rise  (w_arm_edge)
    );

    // Source selects are sampled live from the control word
    assign w_vld  = ctrl_word[CTRL_WE_SRC]   ? 1'b1 : din_valid;
    assign w_trg  = ctrl_word[CTRL_TRIG_SRC] ? 1'b1 : din_trig;
    assign w_last = (r_cnt[ADDR_W-1:0] == {ADDR_W{1'b1}});

    // Capture FSM with its registered write port and done flag
    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
`ifdef SNAP_TRIG_DELAY_EN
            r_dly   <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arm_edge) begin
                        r_state <= ST_ARMED;
                        r_cnt   <= '0;
                    end
                end
                ST_ARMED: begin
                    // A trigger without a valid sample is dropped, not held
                    if (w_trg && w_vld) begin
`ifdef SNAP_TRIG_DELAY_EN
                        if (w_dly_load != '0) begin
                            r_dly   <= w_dly_load;
                            r_state <= ST_DELAY;
                        end else begin
                            r_we    <= 1'b1;
                            r_addr  <= '0;
                            r_data  <= din;
                            r_cnt   <= C_CNT_ONE;
                            r_state <= ST_CAPTURE;
                        end
`else
                        r_we    <= 1'b1;
                        r_addr  <= '0;
                        r_data  <= din;
                        r_cnt   <= C_CNT_ONE;
                        r_state <= ST_CAPTURE;
`endif
                    end
                end
`ifdef SNAP_TRIG_DELAY_EN
                ST_DELAY: begin
                    // Skip qualified samples until the delay has run out
                    if (w_vld) begin
                        if (r_dly == '0) begin
                            r_we    <= 1'b1;
                            r_addr  <= '0;
                            r_data  <= din;
                            r_cnt   <= C_CNT_ONE;
                            r_state <= ST_CAPTURE;
                        end else begin
                            r_dly <= r_dly - 1'b1;
                        end
                    end
                end
`endif
                ST_CAPTURE: begin
                    if (w_vld) begin
                        r_we   <= 1'b1;
                        r_addr <= r_cnt[ADDR_W-1:0];
                        r_data <= din;
                        r_cnt  <= r_cnt + C_CNT_ONE;
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_arm_edge) begin
                        r_state <= ST_ARMED;
                        r_cnt   <= '0;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status word image of the current state and sample count
    always_comb begin
        w_status              = '0;
        w_status[STAT_DONE]   = (r_state == ST_DONE);
        w_status[STAT_BUSY]   = snap_is_busy(r_state);
        w_status[ADDR_W:0]    = r_cnt;
    end

    // Status is registered, so it trails the FSM by one cycle
    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            r_status <= '0;
        end else begin
            r_status <= w_status;
        end
    end

    assign bram_we     = r_we;
    assign bram_addr   = r_addr;
    assign bram_data   = r_data;
    assign status_word = r_status;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: doc/gbe_tx_snapshot_capture.md
Name: gbe_tx_snapshot_capture

Overview:
- Capture controller for the 10GbE TX snapshot path.
- Sits directly downstream of the TX snapshot control software register, which delivers a 32-bit control word in the user_clk domain.
- Edge-detects the arm bit, waits for a trigger, then streams samples into a snapshot BRAM.
- Returns a status word to a simulink-to-ppc register for software readback.

Parameters:
- ADDR_W, 10, BRAM address width; capture depth DEPTH = 2^ADDR_W samples.
- DATA_W, 64, width of the captured sample.
- DLY_W, 16, width of the trigger-delay counter (used only with the optional feature).

Ports:
- user_clk  in  1  sole clock, same domain as the control register output.
- user_rst_n  in  1  synchronous active-low reset.
- ctrl_word  in  32  control register value. Bit0 = arm (rising edge arms). Bit1 = trig_src (1 = immediate, 0 = din_trig). Bit2 = we_src (1 = every cycle valid, 0 = din_valid). Bits[31:16] = trigger delay (feature only).
- din  in  DATA_W  sample to capture.
- din_valid  in  1  sample qualifier.
- din_trig  in  1  external trigger pulse.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_W  BRAM write address.
- bram_data  out  DATA_W  BRAM write data.
- status_word  out  32  bit31 = done; bit30 = busy (armed or capturing); bits[ADDR_W:0] = samples written.
- done  out  1  level, high in DONE state.

Behaviour:
- Reset values: all outputs 0, state IDLE, arm-edge register 0, sample counter 0.
- arm_edge = ctrl_word[0] & ~arm_q, where arm_q is registered each cycle.
  - Only a rising edge arms.
  - Holding arm high does not re-arm.
  - Falling edge has no effect.
- vld = ctrl_word[2] ? 1 : din_valid.
- trg = ctrl_word[1] ? 1 : din_trig.
- States:
  - IDLE: on arm_edge, go to ARMED and clear the counter.
  - ARMED: busy = 1. On trg & vld, go to CAPTURE; that same sample is written at addr 0. trg without vld is ignored; no trigger is remembered.
  - CAPTURE: each vld cycle writes one sample and increments the counter. On the write at addr DEPTH-1, go to DONE.
  - DONE: done = 1, busy = 0, count = DEPTH. On arm_edge, go to ARMED and clear count and done.
- arm_edge while ARMED or CAPTURE is ignored; no restart mid-capture.
- Write pipeline: din, vld and addr are registered once.
  - bram_we/bram_addr/bram_data appear exactly 1 cycle after the qualifying input cycle.
  - bram_we = 0 whenever the state is not writing.
- Counter is ADDR_W+1 bits, so a count of DEPTH is representable; bram_addr = counter[ADDR_W-1:0].
- status_word is registered; it reflects state/count 1 cycle after the change.
- Reset mid-capture: the next cycle is IDLE with count 0 and bram_we 0; BRAM contents are not cleared.
- ctrl_word changes during capture: trig_src/we_src are sampled live; software must not change them while busy.

Optional Feature:
- Macro: SNAP_TRIG_DELAY_EN.
- Defined:
  - Adds a DELAY state between ARMED and CAPTURE.
  - On trg & vld in ARMED, load the delay counter with ctrl_word[16+:DLY_W] and skip that sample.
  - Each vld decrements the counter. The first vld seen with the counter at 0 is written at addr 0.
  - Delay 0 behaves exactly like the non-feature path: the trigger sample is captured.
  - Reset or arm edges in DELAY follow the ARMED rules.
- Not defined: no DELAY state; ctrl_word[31:16] is ignored.

Decomposition:
- Package gbe_snap_pkg:
  - state enum (IDLE, ARMED, DELAY, CAPTURE, DONE);
  - ctrl bit-index constants (CTRL_ARM=0, CTRL_TRIG_SRC=1, CTRL_WE_SRC=2, CTRL_DLY_LSB=16);
  - status bit-index constants (STAT_DONE=31, STAT_BUSY=30).
- One sub-module, snap_edge_detect, providing the registered rising-edge detect for the arm bit.

Test Plan:
- Reset then arm, immediate trigger, we_src=1, ADDR_W=4 -> addr 0..15 written on 16 consecutive cycles starting 2 cycles after arm; done=1; status_word=0x8000_0010.
- Ext trigger with din_valid toggling 1010 and trig on a valid cycle -> exactly 16 writes, only on valid cycles, first write = trigger sample, 1-cycle latency.
- Hold arm high after DONE -> no re-arm; toggle arm 0->1 -> busy=1, done=0, count=0.
- Arm edge and user_rst_n=0 at count 7 during capture -> arm ignored; after reset, state IDLE, bram_we=0, status_word=0.
- din_trig asserted with din_valid=0 in ARMED -> no capture; next trig with valid -> capture starts.
- SNAP_TRIG_DELAY_EN, delay=3, we_src=1 -> the 4th sample after the trigger sample is written at addr 0; delay=0 -> identical to the non-feature run.
